// File: rtl/amdc_ecs_sample_avg_pkg.sv
// amdc_ecs_pkg: shared widths, FSM encoding and accumulator sizing for the eddy-current sample averager.
package amdc_ecs_pkg;
    localparam int DATA_W   = 18;
    localparam int MAX_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CAPT = 2'b01,
        ACC  = 2'b10,
        PUB  = 2'b11
    } state_t;

    // Headroom of MAX_LOG2 bits lets a full window of max-scale samples sum without overflow.
    function automatic int acc_w(input int dw, input int ml);
        return dw + ml;
    endfunction
endpackage

// File: rtl/amdc_ecs_sample_avg_if.sv
// amdc_ecs_sample_avg_if: conversion-done level and X/Y sample bus from the SPI master.
interface amdc_ecs_sample_avg_if #(parameter int DATA_W = amdc_ecs_pkg::DATA_W);
    logic              conv_done;
    logic [DATA_W-1:0] sample_x;
    logic [DATA_W-1:0] sample_y;
    modport master (output conv_done, sample_x, sample_y);
    modport slave  (input  conv_done, sample_x, sample_y);
endinterface

// File: rtl/amdc_ecs_sample_avg_accum.sv
// amdc_ecs_accum: one-channel boxcar accumulator; publishes acc >> k and restarts the window.
module amdc_ecs_accum #(
    parameter int DW = amdc_ecs_pkg::DATA_W,
    parameter int ML = amdc_ecs_pkg::MAX_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add,
    input  logic          pub,
    input  logic [2:0]    k,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] avg
);
    import amdc_ecs_pkg::*;
    localparam int AW = acc_w(DW, ML);
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] avg_q, avg_d;
    always_comb begin
        acc_d = (clr || pub) ? '0 : add ? acc_q + AW'(din) : acc_q;
        avg_d = (pub && !clr) ? DW'(acc_q >> k) : avg_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end
    assign avg = avg_q;
endmodule

// File: rtl/amdc_ecs_sample_avg.sv
// amdc_ecs_sample_avg: captures each SPI conversion and publishes a 2^k-sample boxcar average per channel.
module amdc_ecs_sample_avg #(
    parameter int DATA_W   = amdc_ecs_pkg::DATA_W,
    parameter int MAX_LOG2 = amdc_ecs_pkg::MAX_LOG2,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [2:0]           avg_log2,
    amdc_ecs_sample_avg_if.slave conv,
    output logic [DATA_W-1:0]    raw_x,
    output logic [DATA_W-1:0]    raw_y,
    output logic                 raw_valid,
    output logic [DATA_W-1:0]    avg_x,
    output logic [DATA_W-1:0]    avg_y,
    output logic                 avg_valid,
    output logic [CNT_W-1:0]     sample_cnt
);
    import amdc_ecs_pkg::*;
    localparam int WC_W = MAX_LOG2 + 1;
    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [2:0]        k_lat_q, k_lat_d;
    logic [DATA_W-1:0] raw_x_q, raw_x_d, raw_y_q, raw_y_d;
    logic              raw_valid_q, raw_valid_d, avg_valid_q, avg_valid_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic              evt, kill, accept, full, add;
    logic [2:0]        k_sat;
    always_comb begin
        evt          = conv.conv_done && !done_q;
        kill         = clear || !enable;
        accept       = evt && !kill && state_q == IDLE;
        full         = state_q == ACC && win_cnt_q == (WC_W'(1) << k_lat_q);
        k_sat        = (avg_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : avg_log2;
        done_d       = conv.conv_done;
        state_d      = kill ? IDLE
                     : state_q == IDLE ? (accept ? CAPT : IDLE)
                     : state_q == CAPT ? ACC
                     : state_q == ACC  ? (full ? PUB : IDLE)
                     : IDLE;
        win_cnt_d    = (kill || full) ? '0 : state_q == CAPT ? win_cnt_q + WC_W'(1) : win_cnt_q;
        k_lat_d      = (accept && win_cnt_q == '0) ? k_sat : k_lat_q;
        raw_x_d      = accept ? conv.sample_x : raw_x_q;
        raw_y_d      = accept ? conv.sample_y : raw_y_q;
        raw_valid_d  = accept;
        avg_valid_d  = full && !kill;
        sample_cnt_d = accept ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
        add          = state_q == CAPT && !kill;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            win_cnt_q    <= '0;
            k_lat_q      <= '0;
            raw_x_q      <= '0;
            raw_y_q      <= '0;
            raw_valid_q  <= 1'b0;
            avg_valid_q  <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            win_cnt_q    <= win_cnt_d;
            k_lat_q      <= k_lat_d;
            raw_x_q      <= raw_x_d;
            raw_y_q      <= raw_y_d;
            raw_valid_q  <= raw_valid_d;
            avg_valid_q  <= avg_valid_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end
    amdc_ecs_accum #(.DW(DATA_W), .ML(MAX_LOG2)) u_acc_x (
        .clk(clk), .rst_n(rst_n), .clr(kill), .add(add), .pub(avg_valid_d),
        .k(k_lat_q), .din(raw_x_q), .avg(avg_x)
    );
    amdc_ecs_accum #(.DW(DATA_W), .ML(MAX_LOG2)) u_acc_y (
        .clk(clk), .rst_n(rst_n), .clr(kill), .add(add), .pub(avg_valid_d),
        .k(k_lat_q), .din(raw_y_q), .avg(avg_y)
    );
    assign raw_x      = raw_x_q;
    assign raw_y      = raw_y_q;
    assign raw_valid  = raw_valid_q;
    assign avg_valid  = avg_valid_q;
    assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_amdc_ecs_sample_avg.sv
// tb_amdc_ecs_sample_avg: randomized conversions checked against a queue-based window model.
module tb_amdc_ecs_sample_avg;
    logic        clk = 0, rst_n = 0, enable = 0, clear = 0;
    logic [2:0]  avg_log2 = 0;
    logic [17:0] raw_x, raw_y, avg_x, avg_y;
    logic        raw_valid, avg_valid;
    logic [15:0] sample_cnt;
    int          n_tests = 0, n_fail = 0;

    int unsigned m_cnt = 0, m_k = 0;
    logic [17:0] m_raw_x = 0, m_raw_y = 0, m_avg_x = 0, m_avg_y = 0;
    int unsigned qx[$], qy[$];

    amdc_ecs_sample_avg_if ecs_if();

    amdc_ecs_sample_avg dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .avg_log2(avg_log2),
        .conv(ecs_if), .raw_x(raw_x), .raw_y(raw_y), .raw_valid(raw_valid),
        .avg_x(avg_x), .avg_y(avg_y), .avg_valid(avg_valid), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Conversions must be separated by a falling conv_done; rises closer than 4 cycles are illegal stimulus.
    int   since_rise = 100;
    logic cd_prev = 0;
    always @(posedge clk) begin
        if (ecs_if.conv_done && !cd_prev) begin
            assert (since_rise >= 4) else $error("conv_done rose only %0d cycles after previous rise", since_rise);
            since_rise <= 0;
        end else since_rise <= since_rise + 1;
        cd_prev <= ecs_if.conv_done;
    end

    task automatic convert(input logic [17:0] x, input logic [17:0] y, input int clr_at, input string tag);
        logic [4:0]  rp, ap, erp, eap;
        logic        accepted, exp_avg;
        int unsigned sx, sy;
        @(negedge clk);
        ecs_if.sample_x = x; ecs_if.sample_y = y; ecs_if.conv_done = 1; clear = (clr_at == 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rp[i-1] = raw_valid; ap[i-1] = avg_valid;
            clear = (clr_at == i + 1);
            if (i == 2) ecs_if.conv_done = 0;
        end
        accepted = enable && clr_at != 1;
        exp_avg = 0;
        if (accepted) begin
            m_cnt = (m_cnt + 1) % 65536; m_raw_x = x; m_raw_y = y;
            if (qx.size() == 0) m_k = (avg_log2 > 4) ? 4 : avg_log2;
            qx.push_back(x); qy.push_back(y);
        end
        if (!enable || clr_at != 0) begin
            qx.delete(); qy.delete();
        end else if (qx.size() == (1 << m_k)) begin
            sx = 0; sy = 0;
            foreach (qx[j]) begin sx += qx[j]; sy += qy[j]; end
            m_avg_x = 18'(sx / (1 << m_k)); m_avg_y = 18'(sy / (1 << m_k));
            exp_avg = 1; qx.delete(); qy.delete();
        end
        erp = accepted ? 5'b00001 : 5'b0;
        eap = exp_avg ? 5'b00100 : 5'b0;
        n_tests += 5;
        if (rp !== erp) begin n_fail++; $display("FAIL %s raw_valid pattern got %b exp %b", tag, rp, erp); end
        if (ap !== eap) begin n_fail++; $display("FAIL %s avg_valid pattern got %b exp %b", tag, ap, eap); end
        if ({raw_x, raw_y} !== {m_raw_x, m_raw_y}) begin n_fail++; $display("FAIL %s raw got %h/%h exp %h/%h", tag, raw_x, raw_y, m_raw_x, m_raw_y); end
        if ({avg_x, avg_y} !== {m_avg_x, m_avg_y}) begin n_fail++; $display("FAIL %s avg got %h/%h exp %h/%h", tag, avg_x, avg_y, m_avg_x, m_avg_y); end
        if (sample_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL %s sample_cnt got %h exp %h", tag, sample_cnt, 16'(m_cnt)); end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
        qx.delete(); qy.delete();
    endtask

    task automatic test_reset();
        logic [4:0] rp, ap;
        enable = 1; avg_log2 = 0;
        ecs_if.sample_x = 18'd5; ecs_if.sample_y = 18'd7; ecs_if.conv_done = 1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({raw_x, raw_y, avg_x, avg_y, raw_valid, avg_valid, sample_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_values got raw %h/%h avg %h/%h cnt %h", raw_x, raw_y, avg_x, avg_y, sample_cnt);
        end
        rst_n = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rp[i-1] = raw_valid; ap[i-1] = avg_valid;
            if (i == 2) ecs_if.conv_done = 0;
        end
        m_cnt = 1; m_raw_x = 5; m_raw_y = 7; m_avg_x = 5; m_avg_y = 7;
        n_tests += 3;
        if (rp !== 5'b00001 || ap !== 5'b00100) begin n_fail++; $display("FAIL release_event pulses got %b/%b exp 00001/00100", rp, ap); end
        if ({avg_x, avg_y} !== {18'd5, 18'd7}) begin n_fail++; $display("FAIL release_event avg got %h/%h exp 5/7", avg_x, avg_y); end
        if (sample_cnt !== 16'd1) begin n_fail++; $display("FAIL release_event cnt got %h exp 1", sample_cnt); end
    endtask

    task automatic test_k0();
        avg_log2 = 0;
        convert(18'h12345, 18'h00001, 0, "k0");
        n_tests++;
        if ({avg_x, avg_y} !== {18'h12345, 18'h00001}) begin n_fail++; $display("FAIL k0_passthru got %h/%h exp 12345/00001", avg_x, avg_y); end
    endtask

    task automatic test_k2();
        int xs[4] = '{10, 11, 12, 14};
        avg_log2 = 2;
        foreach (xs[i]) convert(18'(xs[i]), 18'($urandom_range(0, 18'h3FFFF)), 0, "k2");
        n_tests++;
        if (avg_x !== 18'd11) begin n_fail++; $display("FAIL k2_avg got %0d exp 11", avg_x); end
    endtask

    task automatic test_k4_switch();
        avg_log2 = 4;
        repeat (16) convert(18'h3FFFF, 18'h3FFFF, 0, "k4_full");
        n_tests++;
        if ({avg_x, avg_y} !== {18'h3FFFF, 18'h3FFFF}) begin n_fail++; $display("FAIL k4_no_overflow got %h/%h exp 3ffff", avg_x, avg_y); end
        for (int i = 0; i < 16; i++) begin
            if (i == 3) avg_log2 = 1;
            convert(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)), 0, "k_switch16");
        end
        repeat (2) convert(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)), 0, "k_switch2");
    endtask

    task automatic test_clear();
        logic [15:0] cnt_before;
        avg_log2 = 2;
        repeat (2) convert(18'($urandom_range(0, 999)), 18'd3, 0, "clr_partial");
        pulse_clear();
        repeat (4) convert(18'd100, 18'd200, 0, "clr_refill");
        n_tests++;
        if ({avg_x, avg_y} !== {18'd100, 18'd200}) begin n_fail++; $display("FAIL clr_refill avg got %0d/%0d exp 100/200", avg_x, avg_y); end
        cnt_before = sample_cnt;
        convert(18'd55, 18'd66, 1, "clr_coincident");
        n_tests++;
        if (sample_cnt !== cnt_before) begin n_fail++; $display("FAIL clr_coincident cnt got %h exp %h", sample_cnt, cnt_before); end
        avg_log2 = 0;
        convert(18'd77, 18'd88, 2, "clr_in_capt");
        convert(18'd99, 18'd11, 3, "clr_in_acc");
    endtask

    task automatic test_enable();
        logic seen;
        enable = 0;
        repeat (3) convert(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)), 0, "en_low");
        @(negedge clk); ecs_if.sample_x = 18'h2AAAA; ecs_if.conv_done = 1;
        @(negedge clk); enable = 1;
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= raw_valid | avg_valid; end
        ecs_if.conv_done = 0;
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL en_rise_high spurious pulse got %b exp 0", seen); end
        repeat (3) @(negedge clk);
        avg_log2 = 0;
        convert(18'h01234, 18'h04321, 0, "en_resume");
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) avg_log2 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            convert(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)), (r < 7) ? 0 : r - 6, "random");
        end
    endtask

    task automatic test_wrap();
        avg_log2 = 0;
        pulse_clear();
        @(negedge clk);
        force dut.sample_cnt_q = 16'hFFFE;
        #1 release dut.sample_cnt_q;
        m_cnt = 16'hFFFE;
        convert(18'd1, 18'd2, 0, "wrap_ffff");
        convert(18'd3, 18'd4, 0, "wrap_0");
        n_tests++;
        if (sample_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap cnt got %h exp 0000", sample_cnt); end
    endtask

    task automatic test_async_reset();
        logic seen;
        avg_log2 = 0;
        @(negedge clk); ecs_if.sample_x = 18'h1F00F; ecs_if.sample_y = 18'h00F0F; ecs_if.conv_done = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        n_tests++;
        if ({raw_x, raw_y, avg_x, avg_y, raw_valid, avg_valid, sample_cnt} !== '0) begin
            n_fail++; $display("FAIL async_reset got raw %h/%h avg %h/%h cnt %h", raw_x, raw_y, avg_x, avg_y, sample_cnt);
        end
        ecs_if.conv_done = 0;
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= avg_valid | raw_valid; end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL async_reset pulse got %b exp 0", seen); end
        rst_n = 1;
        m_cnt = 0; m_raw_x = 0; m_raw_y = 0; m_avg_x = 0; m_avg_y = 0;
        qx.delete(); qy.delete();
        repeat (2) @(negedge clk);
        convert(18'h00ABC, 18'h00DEF, 0, "post_reset");
    endtask

    initial begin
        ecs_if.conv_done = 0; ecs_if.sample_x = 0; ecs_if.sample_y = 0;
        test_reset();
        test_k0();
        test_k2();
        test_k4_switch();
        test_clear();
        test_enable();
        test_random();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
